demux3b16_buf: RTL and testbench

Registered 1-to-3 distributor for 16-bit datapath values: the counterpart of the 3-input result mux, steering a single producer stream to one of three consumers by a 2-bit select. Each output channel has a one-entry holding register with valid/ready handshaking, so a stalled consumer back-pressures only the producer words aimed at it. Select code 3 is illegal; such words are dropped and counted.

---
 rtl/demux3b16_buf.sv | 99 +++++++++
 tb/tb_demux3b16_buf.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/demux3b16_buf.sv
// demux3b16_buf: registered 1-to-3 distributor.
// Each of the three channels owns a one-entry holding register with its own
// valid/ready handshake. The producer is stalled only when the channel it
// addresses is full and that channel's consumer is not taking its word.
// Select code 3 is illegal; such words are swallowed, flagged and counted.
module demux3b16_buf #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [WIDTH-1:0] In,
  input  logic [1:0]       S,
  input  logic             InValid,
  output logic             InReady,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB,
  output logic [WIDTH-1:0] OutC,
  output logic             ValidA,
  output logic             ValidB,
  output logic             ValidC,
  input  logic             ReadyA,
  input  logic             ReadyB,
  input  logic             ReadyC,
  output logic             Err,
  output logic [7:0]       DropCount
);

  localparam logic [1:0] SEL_ILLEGAL = 2'd3;

  // Channel state gathered into vectors so the per-channel logic is generated once.
  logic [2:0]       ready_vec;
  logic [2:0]       valid_reg;
  logic [WIDTH-1:0] data_reg [3];
  logic [2:0]       load_vec;
  logic             accept;
  logic             drop;
  logic             err_reg;
  logic [7:0]       drop_count_reg;

  assign ready_vec = {ReadyC, ReadyB, ReadyA};

  // Acceptance depends only on the select and the addressed channel's state,
  // never on the data word; illegal selects are always taken so they cannot stall.
  always_comb begin
    InReady = 1'b1;
    case (S)
      2'd0:    InReady = !valid_reg[0] || ready_vec[0];
      2'd1:    InReady = !valid_reg[1] || ready_vec[1];
      2'd2:    InReady = !valid_reg[2] || ready_vec[2];
      default: InReady = 1'b1;
    endcase
  end

  assign accept = InValid && InReady;
  assign drop   = accept && (S == SEL_ILLEGAL);

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      assign load_vec[gi] = accept && (S == 2'(gi));

      // Channel register: a load wins over a same-cycle drain, so a full
      // channel with a ready consumer sustains one word per cycle.
      always_ff @(posedge CLK) begin
        if (Reset) begin
          valid_reg[gi] <= 1'b0;
          data_reg[gi]  <= '0;
        end else if (load_vec[gi]) begin
          valid_reg[gi] <= 1'b1;
          data_reg[gi]  <= In;
        end else if (valid_reg[gi] && ready_vec[gi]) begin
          valid_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  // Illegal-select bookkeeping: sticky flag plus a counter that stops at 255.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      err_reg        <= 1'b0;
      drop_count_reg <= 8'd0;
    end else if (drop) begin
      err_reg <= 1'b1;
      if (drop_count_reg != 8'hFF) begin
        drop_count_reg <= drop_count_reg + 8'd1;
      end
    end
  end

  assign OutA      = data_reg[0];
  assign OutB      = data_reg[1];
  assign OutC      = data_reg[2];
  assign ValidA    = valid_reg[0];
  assign ValidB    = valid_reg[1];
  assign ValidC    = valid_reg[2];
  assign Err       = err_reg;
  assign DropCount = drop_count_reg;

endmodule

// File: tb/tb_demux3b16_buf.sv
// Directed and scoreboarded bench for demux3b16_buf.
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
module tb_demux3b16_buf;

  logic        clk;
  logic        reset;
  logic [15:0] in_data;
  logic [1:0]  sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_a, out_b, out_c;
  logic        valid_a, valid_b, valid_c;
  logic [2:0]  rdy;
  logic        err;
  logic [7:0]  drop_count;

  logic [15:0] outs [3];
  logic [2:0]  valids;

  int tests = 0;
  int fails = 0;

  demux3b16_buf #(.WIDTH(16)) dut (
    .CLK       (clk),
    .Reset     (reset),
    .In        (in_data),
    .S         (sel),
    .InValid   (in_valid),
    .InReady   (in_ready),
    .OutA      (out_a),
    .OutB      (out_b),
    .OutC      (out_c),
    .ValidA    (valid_a),
    .ValidB    (valid_b),
    .ValidC    (valid_c),
    .ReadyA    (rdy[0]),
    .ReadyB    (rdy[1]),
    .ReadyC    (rdy[2]),
    .Err       (err),
    .DropCount (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    outs[0] = out_a;
    outs[1] = out_b;
    outs[2] = out_c;
    valids  = {valid_c, valid_b, valid_a};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [15:0] d);
    in_valid = v;
    sel      = s;
    in_data  = d;
  endtask

  // Random-phase scoreboard state
  logic [15:0] q [3][$];
  int          sent [3];
  int          recv [3];
  int          model_drops;
  logic        exp_rdy;
  logic [15:0] exp_word;

  initial begin
    reset = 1'b1;
    rdy   = 3'b111;
    drive(1'b0, 2'd0, 16'h0);
    step();
    step();
    reset = 1'b0;

    // Reset state
    check("rst_valid", {29'd0, valids}, 32'd0);
    check("rst_outa", {16'd0, out_a}, 32'd0);
    check("rst_outc", {16'd0, out_c}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_drop", {24'd0, drop_count}, 32'd0);

    // Three words to three channels, all consumers ready
    drive(1'b1, 2'd0, 16'd5);
    check("t1_rdy_a", {31'd0, in_ready}, 32'd1);
    step();
    check("t1_valid_a", {29'd0, valids}, 32'b001);
    check("t1_out_a", {16'd0, out_a}, 32'd5);
    drive(1'b1, 2'd1, 16'd10);
    step();
    check("t1_valid_b", {29'd0, valids}, 32'b010);
    check("t1_out_b", {16'd0, out_b}, 32'd10);
    drive(1'b1, 2'd2, 16'd15);
    step();
    check("t1_valid_c", {29'd0, valids}, 32'b100);
    check("t1_out_c", {16'd0, out_c}, 32'd15);
    drive(1'b0, 2'd0, 16'd0);
    step();
    check("t1_idle_valid", {29'd0, valids}, 32'd0);
    check("t1_hold_c", {16'd0, out_c}, 32'd15);
    check("t1_err", {31'd0, err}, 32'd0);

    // Back-pressure on B, then simultaneous drain and load
    rdy = 3'b101;
    drive(1'b1, 2'd1, 16'd10);
    check("t2_rdy_first", {31'd0, in_ready}, 32'd1);
    step();
    check("t2_valid_b", {31'd0, valid_b}, 32'd1);
    check("t2_out_b", {16'd0, out_b}, 32'd10);
    drive(1'b1, 2'd1, 16'd11);
    check("t2_stall", {31'd0, in_ready}, 32'd0);
    step();
    check("t2_hold_b", {16'd0, out_b}, 32'd10);
    check("t2_hold_vb", {31'd0, valid_b}, 32'd1);
    rdy = 3'b111;
    check("t2_rdy_again", {31'd0, in_ready}, 32'd1);
    step();
    check("t2_reload_b", {16'd0, out_b}, 32'd11);
    check("t2_reload_vb", {31'd0, valid_b}, 32'd1);
    drive(1'b0, 2'd0, 16'd0);
    step();
    check("t2_drain_b", {31'd0, valid_b}, 32'd0);

    // Stalled A must not block C
    rdy = 3'b110;
    drive(1'b1, 2'd0, 16'd7);
    step();
    check("t3_out_a", {16'd0, out_a}, 32'd7);
    drive(1'b1, 2'd2, 16'd9);
    check("t3_rdy_c", {31'd0, in_ready}, 32'd1);
    step();
    check("t3_out_c", {16'd0, out_c}, 32'd9);
    check("t3_valid", {29'd0, valids}, 32'b101);
    check("t3_keep_a", {16'd0, out_a}, 32'd7);
    drive(1'b0, 2'd0, 16'd0);
    rdy = 3'b111;
    step();
    check("t3_empty", {29'd0, valids}, 32'd0);

    // 300 illegal words: always accepted, counter saturates, no channel loads
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 2'd3, 16'(i));
      check("t4_rdy", {31'd0, in_ready}, 32'd1);
      step();
      check("t4_err", {31'd0, err}, 32'd1);
      check("t4_drop", {24'd0, drop_count}, (i + 1 > 255) ? 32'd255 : 32'(i + 1));
      check("t4_novalid", {29'd0, valids}, 32'd0);
    end
    drive(1'b0, 2'd0, 16'd0);
    step();
    check("t4_drop_final", {24'd0, drop_count}, 32'd255);

    // Reset while A and B are full and a word for C is offered
    rdy = 3'b000;
    drive(1'b1, 2'd0, 16'h1111);
    step();
    drive(1'b1, 2'd1, 16'h2222);
    step();
    check("t5_pre_valid", {29'd0, valids}, 32'b011);
    reset = 1'b1;
    drive(1'b1, 2'd2, 16'h3333);
    step();
    reset = 1'b0;
    drive(1'b0, 2'd0, 16'd0);
    check("t5_valid", {29'd0, valids}, 32'd0);
    check("t5_out_a", {16'd0, out_a}, 32'd0);
    check("t5_out_b", {16'd0, out_b}, 32'd0);
    check("t5_out_c", {16'd0, out_c}, 32'd0);
    check("t5_err", {31'd0, err}, 32'd0);
    check("t5_drop", {24'd0, drop_count}, 32'd0);

    // Random traffic against a per-channel in-order scoreboard
    model_drops = 0;
    for (int c = 0; c < 3; c++) begin
      sent[c] = 0;
      recv[c] = 0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rdy = 3'($urandom_range(0, 7));
      if (!in_valid && ($urandom_range(0, 3) != 0)) begin
        drive(1'b1, 2'($urandom_range(0, 3)), 16'($urandom));
      end
      #0;
      exp_rdy = (sel == 2'd3) || (q[sel].size() == 0) || rdy[sel];
      if (in_valid) check("rnd_inready", {31'd0, in_ready}, {31'd0, exp_rdy});
      for (int c = 0; c < 3; c++) begin
        check("rnd_valid", {31'd0, valids[c]}, {31'd0, q[c].size() != 0});
        if (q[c].size() != 0 && rdy[c]) begin
          exp_word = q[c].pop_front();
          check("rnd_data", {16'd0, outs[c]}, {16'd0, exp_word});
          recv[c]++;
        end
      end
      if (in_valid && exp_rdy) begin
        if (sel == 2'd3) begin
          if (model_drops < 255) model_drops++;
        end else begin
          q[sel].push_back(in_data);
          sent[sel]++;
        end
      end
      step();
      if (in_valid && exp_rdy) in_valid = 1'b0;
    end
    drive(1'b0, 2'd0, 16'd0);
    for (int c = 0; c < 3; c++) begin
      check("rnd_count", 32'(recv[c] + q[c].size()), 32'(sent[c]));
    end
    check("rnd_drop", {24'd0, drop_count}, 32'(model_drops));
    check("rnd_err", {31'd0, err}, {31'd0, model_drops != 0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
